// File: rtl/coax_rx_word_packer.sv
// coax_rx_word_packer: drains the RX FIFO and serializes each 10-bit word (or an in-band
// marker) as two bytes, low byte first. Optional FETCH timeout: COAX_RX_PACKER_TIMEOUT_EN.
module coax_rx_word_packer #(
    parameter int COUNT_WIDTH    = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_sent,
    input  logic [9:0]             fifo_data,
    input  logic                   fifo_empty,
    output logic                   fifo_read_strobe,
    input  logic                   rx_active,
    input  logic                   rx_error,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready
);

    localparam logic [15:0] MARK_ERR     = 16'h4000;
    localparam logic [15:0] MARK_END     = 16'h8000;
    localparam logic [15:0] MARK_TIMEOUT = 16'h2000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        SEND_LO = 3'd2,
        SEND_HI = 3'd3,
        FINISH  = 3'd4
    } state_t;

    typedef struct packed {
        logic [15:0] word;
        logic        last;
        logic        marker;
    } pend_t;

    state_t                 state, state_d;
    pend_t                  pend, pend_d;
    logic                   cap_en;
    logic                   pop_d;
    logic                   sent_inc;
    logic                   handshake;
    logic                   timeout_hit;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH:0]   ws_plus1;

    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign byte_valid = (state == SEND_LO) || (state == SEND_HI);
    assign handshake  = byte_valid && byte_ready;
    assign ws_plus1   = {1'b0, words_sent} + 1'b1;

    // Gate the byte bus so stale words never show outside a send.
    always_comb begin
        byte_data = 8'h00;
        if (state == SEND_LO)
            byte_data = pend.word[7:0];
        else if (state == SEND_HI)
            byte_data = pend.word[15:8];
    end

`ifdef COAX_RX_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          waiting;

    assign waiting     = (state == FETCH) && fifo_empty && !rx_error && rx_active;
    assign timeout_hit = waiting && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state != FETCH)
            wait_cnt <= '0;
        else if (waiting && !timeout_hit)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        pend_d   = pend;
        cap_en   = 1'b0;
        pop_d    = 1'b0;
        sent_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_d = (count == '0) ? FINISH : FETCH;
            end
            FETCH: begin
                if (abort) begin
                    state_d = FINISH;
                end else if (!fifo_empty) begin
                    cap_en  = 1'b1;
                    pop_d   = 1'b1;
                    pend_d  = '{word: {6'b0, fifo_data}, last: (ws_plus1 == {1'b0, count_q}), marker: 1'b0};
                    state_d = SEND_LO;
                end else if (rx_error) begin
                    cap_en  = 1'b1;
                    pend_d  = '{word: MARK_ERR, last: 1'b1, marker: 1'b1};
                    state_d = SEND_LO;
                end else if (!rx_active) begin
                    cap_en  = 1'b1;
                    pend_d  = '{word: MARK_END, last: 1'b1, marker: 1'b1};
                    state_d = SEND_LO;
                end else if (timeout_hit) begin
                    cap_en  = 1'b1;
                    pend_d  = '{word: MARK_TIMEOUT, last: 1'b1, marker: 1'b1};
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (abort)
                    state_d = FINISH;
                else if (handshake)
                    state_d = SEND_HI;
            end
            SEND_HI: begin
                // A completing handshake still counts when abort lands on the same edge.
                if (handshake) begin
                    sent_inc = !pend.marker;
                    state_d  = (pend.marker || pend.last) ? FINISH : FETCH;
                end
                if (abort)
                    state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            pend             <= '0;
            count_q          <= '0;
            words_sent       <= '0;
            fifo_read_strobe <= 1'b0;
        end else begin
            state            <= state_d;
            fifo_read_strobe <= pop_d;
            if (cap_en)
                pend <= pend_d;
            if (state == IDLE && start) begin
                count_q    <= count;
                words_sent <= '0;
            end else if (sent_inc && words_sent != {COUNT_WIDTH{1'b1}}) begin
                words_sent <= words_sent + 1'b1;
            end
        end
    end

endmodule
